// File: rtl/alu_issue.sv
// alu_issue: command queue and sequencer in front of an external ALU.
//
// Commands (opcode, two 65-bit operands, 4-bit tag) are queued in a DEPTH-entry
// FIFO. One command at a time is issued to the ALU through alu_sel/alu_a/alu_b,
// which stay constant while the ALU evaluates. Multiply, divide and modulo
// take MC_CYCLES cycles; every other opcode takes one. The ALU result is
// captured with its tag and presented on a valid/ready result port.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          command handshake
//   in_sel, in_a, in_b, in_tag command fields
//   alu_sel, alu_a, alu_b      operands driven to the ALU
//   alu_out                    result returned by the ALU
//   res_valid/res_ready        result handshake
//   res_data, res_tag, res_dz  captured result, its tag, divide-by-zero flag
//   count                      FIFO occupancy
//   busy                       sequencer active or commands queued
module alu_issue #(
  parameter int DEPTH     = 4,
  parameter int MC_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_sel,
  input  logic [64:0]           in_a,
  input  logic [64:0]           in_b,
  input  logic [3:0]            in_tag,
  output logic [3:0]            alu_sel,
  output logic [64:0]           alu_a,
  output logic [64:0]           alu_b,
  input  logic [64:0]           alu_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [64:0]           res_data,
  output logic [3:0]            res_tag,
  output logic                  res_dz,
  output logic [$clog2(DEPTH):0] count,
  output logic                  busy
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_e;

  // Multiply (0010), divide (0011) and modulo (0100) need the long evaluation.
  function automatic logic is_multi(input logic [3:0] sel);
    return (sel == 4'b0010) || (sel == 4'b0011) || (sel == 4'b0100);
  endfunction

  // Divide and modulo are the opcodes with a zero-divisor hazard.
  function automatic logic is_div(input logic [3:0] sel);
    return (sel == 4'b0011) || (sel == 4'b0100);
  endfunction

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic [64:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]        tag_q, tag_d;
  logic              res_valid_q, res_valid_d;
  logic [64:0]       res_data_q, res_data_d;
  logic [3:0]        res_tag_q, res_tag_d;
  logic              res_dz_q, res_dz_d;
  logic [3:0]        fifo_sel_q [DEPTH];
  logic [3:0]        fifo_sel_d [DEPTH];
  logic [64:0]       fifo_a_q   [DEPTH];
  logic [64:0]       fifo_a_d   [DEPTH];
  logic [64:0]       fifo_b_q   [DEPTH];
  logic [64:0]       fifo_b_d   [DEPTH];
  logic [3:0]        fifo_tag_q [DEPTH];
  logic [3:0]        fifo_tag_d [DEPTH];
  logic              push, pop;

  // Next-state logic for the sequencer, FIFO pointers and result capture.
  always_comb begin
    // Full is judged on the current count, so a pop cannot free a slot for a
    // push in the same cycle.
    push        = in_valid && (count_q < DEPTH_C);
    pop         = 1'b0;
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cnt_d       = cnt_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    tag_d       = tag_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_dz_d    = res_dz_q;
    fifo_sel_d  = fifo_sel_q;
    fifo_a_d    = fifo_a_q;
    fifo_b_d    = fifo_b_q;
    fifo_tag_d  = fifo_tag_q;

    case (state_q)
      IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          pop     = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d   = RESULT;
          res_tag_d = tag_q;
          // A zero divisor yields a defined zero result rather than whatever
          // the ALU happens to produce.
          if (is_div(alu_sel_q) && (alu_b_q == 65'd0)) begin
            res_data_d = 65'd0;
            res_dz_d   = 1'b1;
          end else begin
            res_data_d = alu_out;
            res_dz_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESULT: begin
        if (res_ready) begin
          if (count_q != {CW{1'b0}}) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Issue: operands are only ever loaded on a pop, so they hold between
    // commands.
    if (pop) begin
      alu_sel_d = fifo_sel_q[rd_ptr_q];
      alu_a_d   = fifo_a_q[rd_ptr_q];
      alu_b_d   = fifo_b_q[rd_ptr_q];
      tag_d     = fifo_tag_q[rd_ptr_q];
      cnt_d     = is_multi(fifo_sel_q[rd_ptr_q]) ? MC_LOAD : {CNT_W{1'b0}};
      rd_ptr_d  = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d  = rd_ptr_q;
    end

    if (push) begin
      fifo_sel_d[wr_ptr_q] = in_sel;
      fifo_a_d[wr_ptr_q]   = in_a;
      fifo_b_d[wr_ptr_q]   = in_b;
      fifo_tag_d[wr_ptr_q] = in_tag;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d             = wr_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    res_valid_d = (state_d == RESULT);
  end

  // State, FIFO and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      alu_sel_q   <= 4'd0;
      alu_a_q     <= 65'd0;
      alu_b_q     <= 65'd0;
      tag_q       <= 4'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 65'd0;
      res_tag_q   <= 4'd0;
      res_dz_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_sel_q[i] <= 4'd0;
        fifo_a_q[i]   <= 65'd0;
        fifo_b_q[i]   <= 65'd0;
        fifo_tag_q[i] <= 4'd0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_dz_q    <= res_dz_d;
      fifo_sel_q  <= fifo_sel_d;
      fifo_a_q    <= fifo_a_d;
      fifo_b_q    <= fifo_b_d;
      fifo_tag_q  <= fifo_tag_d;
    end
  end

  assign in_ready  = (count_q < DEPTH_C);
  assign busy      = (state_q != IDLE) || (count_q != {CW{1'b0}});
  assign count     = count_q;
  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_dz    = res_dz_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue (DEPTH=4, MC_CYCLES=4).
// A behavioural ALU drives alu_out from alu_sel/alu_a/alu_b; expected results
// go into a scoreboard queue when a command is accepted and are compared when
// the result handshake occurs.
module tb_alu_issue;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic [64:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [3:0]  alu_sel;
  logic [64:0] alu_a, alu_b;
  logic [64:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [64:0] res_data;
  logic [3:0]  res_tag;
  logic        res_dz;
  logic [2:0]  count;
  logic        busy;

  alu_issue #(.DEPTH(4), .MC_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_dz(res_dz),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; division by zero returns all ones so masking is visible.
  function automatic logic [64:0] alu_model(input logic [3:0] s, input logic [64:0] a, input logic [64:0] b);
    case (s)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return (b == 65'd0) ? {65{1'b1}} : a / b;
      4'h4: return (b == 65'd0) ? {65{1'b1}} : a % b;
      4'h5: return a & b;
      4'h6: return a | b;
      4'h7: return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb alu_out = alu_model(alu_sel, alu_a, alu_b);

  typedef struct {
    logic [64:0] data;
    logic [3:0]  tag;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [3:0]  sel;
    logic [64:0] a;
    logic [64:0] b;
    logic [3:0]  tag;
    logic [64:0] data;
    logic        dz;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Offer one command (call just after a rising edge); returns just after the
  // accepting edge with in_valid dropped.
  task automatic issue(input logic [3:0] s, input logic [64:0] a, input logic [64:0] b,
                       input logic [3:0] t, input logic [64:0] ed, input logic edz);
    int   n;
    exp_t e;
    in_valid = 1'b1;
    in_sel   = s;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tout("issue_accept");
    end else begin
      e.data = ed;
      e.tag  = t;
      e.dz   = edz;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait until every expected result has been seen; ends just after an edge.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) tout("drain");
    @(negedge clk);
    chk("idle_busy", 65'(busy), 65'd0);
    chk("idle_res_valid", 65'(res_valid), 65'd0);
    @(posedge clk);
    #1;
  endtask

  // Single command from an empty, idle DUT: check latency and operand hold.
  task automatic lat_run(input logic [3:0] s, input logic [64:0] a, input logic [64:0] b,
                         input logic [3:0] t, input logic [64:0] ed, input logic edz, input int exp_lat);
    int n;
    issue(s, a, b, t, ed, edz);
    chk("count_after_push", 65'(count), 65'd1);
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 50) begin
      if (busy && count == 3'd0) begin
        chk("exec_alu_sel", 65'(alu_sel), 65'(s));
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 65'(n), 65'(exp_lat));
    @(posedge clk);
    #1;
    chk("hold_alu_sel", 65'(alu_sel), 65'(s));
    chk("hold_alu_b", alu_b, b);
    chk("sb_empty", 65'(sb.size()), 65'd0);
  endtask

  initial begin
    exp_t e;
    tbl[0]  = '{4'h0, 65'd5,   65'd7,  4'h1, 65'd12,  1'b0};
    tbl[1]  = '{4'h1, 65'd10,  65'd3,  4'h2, 65'd7,   1'b0};
    tbl[2]  = '{4'h2, 65'd6,   65'd7,  4'h3, 65'd42,  1'b0};
    tbl[3]  = '{4'h3, 65'd100, 65'd7,  4'h4, 65'd14,  1'b0};
    tbl[4]  = '{4'h4, 65'd100, 65'd7,  4'h5, 65'd2,   1'b0};
    tbl[5]  = '{4'h3, 65'd7,   65'd0,  4'h6, 65'd0,   1'b1};
    tbl[6]  = '{4'h5, 65'hF0,  65'h3C, 4'h7, 65'h30,  1'b0};
    tbl[7]  = '{4'h6, 65'hF0,  65'h0F, 4'h8, 65'hFF,  1'b0};
    tbl[8]  = '{4'h7, 65'hFF,  65'h0F, 4'h9, 65'hF0,  1'b0};
    tbl[9]  = '{4'h0, 65'h1_FFFF_FFFF_FFFF_FFFF, 65'd1, 4'hA, 65'd0, 1'b0};
    tbl[10] = '{4'h8, 65'h123, 65'd9,  4'hB, 65'h123, 1'b0};
    tbl[11] = '{4'h1, 65'd0,   65'd0,  4'hC, 65'd0,   1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 4'd0;
    in_a      = 65'd0;
    in_b      = 65'd0;
    in_tag    = 4'd0;
    res_ready = 1'b1;

    // Result monitor: compare at the negedge before each handshake edge.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && res_valid && res_ready) begin
          if (sb.size() == 0) begin
            tout("unexpected_result");
          end else begin
            e = sb.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_tag", 65'(res_tag), 65'(e.tag));
            chk("res_dz", 65'(res_dz), 65'(e.dz));
          end
        end
      end
    join_none

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 65'(in_ready), 65'd1);
    chk("rst_res_valid", 65'(res_valid), 65'd0);
    chk("rst_count", 65'(count), 65'd0);
    chk("rst_busy", 65'(busy), 65'd0);
    chk("rst_alu_sel", 65'(alu_sel), 65'd0);
    chk("rst_res_data", res_data, 65'd0);

    // Release just after an edge; the first push lands on the next edge.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat_run(4'h0, 65'd5,   65'd7, 4'h3, 65'd12, 1'b0, 2);
    lat_run(4'h3, 65'd100, 65'd7, 4'h1, 65'd14, 1'b0, 1 + MC);
    lat_run(4'h4, 65'd9,   65'd0, 4'h2, 65'd0,  1'b1, 1 + MC);

    // Table of vectors, issued back to back with res_ready high.
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].data, tbl[i].dz);
    end
    drain();

    // Backpressure: fill the FIFO behind a stalled result.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(4'h0, 65'(i * 10), 65'(i), 4'(i), 65'(i * 11), 1'b0);
    end
    in_valid = 1'b1;
    in_sel   = 4'h0;
    in_a     = 65'd50;
    in_b     = 65'd5;
    in_tag   = 4'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_count", 65'(count), 65'd4);
      chk("full_in_ready", 65'(in_ready), 65'd0);
      chk("stall_res_valid", 65'(res_valid), 65'd1);
      chk("stall_res_tag", 65'(res_tag), 65'd0);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("pop_edge_count", 65'(count), 65'd4);
    chk("pop_edge_in_ready", 65'(in_ready), 65'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_pop_count", 65'(count), 65'd3);
    chk("after_pop_in_ready", 65'(in_ready), 65'd1);
    if (in_ready) begin
      e.data = 65'd55;
      e.tag  = 4'd5;
      e.dz   = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("late_push_count", 65'(count), 65'd4);
    @(posedge clk);
    #1;
    drain();

    // Reset in the middle of a multiply with another command queued.
    issue(4'h2, 65'd3, 65'd4, 4'd9, 65'd12, 1'b0);
    issue(4'h0, 65'd1, 65'd1, 4'd8, 65'd2,  1'b0);
    @(negedge clk);
    chk("pre_rst_busy", 65'(busy), 65'd1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_res_valid", 65'(res_valid), 65'd0);
    chk("mid_rst_count", 65'(count), 65'd0);
    chk("mid_rst_in_ready", 65'(in_ready), 65'd1);
    chk("mid_rst_busy", 65'(busy), 65'd0);
    chk("mid_rst_alu_sel", 65'(alu_sel), 65'd0);
    chk("mid_rst_alu_a", alu_a, 65'd0);
    chk("mid_rst_alu_b", alu_b, 65'd0);
    chk("mid_rst_res_tag", 65'(res_tag), 65'd0);
    chk("mid_rst_res_dz", 65'(res_dz), 65'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_res_valid", 65'(res_valid), 65'd0);
      chk("post_rst_busy", 65'(busy), 65'd0);
    end
    @(posedge clk);
    #1;
    issue(4'h0, 65'd1, 65'd2, 4'd4, 65'd3, 1'b0);
    chk("post_rst_push_count", 65'(count), 65'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
